// File: rtl/core_acc_quant_pkg.sv
// Shared defaults, accumulator FSM states and saturation helper
// for the MAC accumulate/quantize block.
package core_acc_quant_pkg;

  localparam int DEF_ACC_BIT    = 32;
  localparam int DEF_ODATA_BIT  = 8;
  localparam int DEF_LEN_BIT    = 8;
  localparam int DEF_SHIFT_BIT  = 5;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  // Clamp a signed value to the range of an n-bit signed number.
  function automatic logic signed [63:0] sat_n(
    input logic signed [63:0] v,
    input int unsigned        n
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/core_acc_quant_fifo.sv
// First-word-fall-through sync FIFO for quantized results.
// A push into a full FIFO without a pop is dropped and reported.
module acc_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             pop;
  logic             wr_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign pop     = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || pop);
  assign drop_o  = push_i && full_o && !pop;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Storage array, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/core_acc_quant.sv
// Accumulates signed MAC partial sums, then bias/round/shift/ReLU
// and saturates into a small output FIFO with valid/ready.
module core_acc_quant
  import core_acc_quant_pkg::*;
#(
  parameter int MAC_MULT_NUM = 64,
  parameter int IDATA_WIDTH  = 8,
  parameter int IDATA_BIT    = 2*IDATA_WIDTH+$clog2(MAC_MULT_NUM),
  parameter int ACC_BIT      = DEF_ACC_BIT,
  parameter int ODATA_BIT    = DEF_ODATA_BIT,
  parameter int LEN_BIT      = DEF_LEN_BIT,
  parameter int SHIFT_BIT    = DEF_SHIFT_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LEN_BIT-1:0]          cfg_acc_num,
  input  logic [SHIFT_BIT-1:0]        cfg_shift,
  input  logic signed [ACC_BIT-1:0]   cfg_bias,
  input  logic                        cfg_relu,
  input  logic                        clear,
  input  logic signed [IDATA_BIT-1:0] idata,
  input  logic                        idata_valid,
  output logic signed [ODATA_BIT-1:0] odata,
  output logic                        odata_valid,
  input  logic                        odata_ready,
  output logic                        busy,
  output logic                        acc_sat_err,
  output logic                        ovf_err
);

  typedef logic signed [ACC_BIT+1:0] qw_t;

  state_e                     state_q, state_d;
  logic [LEN_BIT-1:0]         cnt_q, cnt_d;
  logic [LEN_BIT-1:0]         num_q;
  logic [SHIFT_BIT-1:0]       shift_q;
  logic signed [ACC_BIT-1:0]  bias_q;
  logic                       relu_q;
  logic signed [ACC_BIT-1:0]  acc_q, acc_d;
  logic                       qv_q;
  logic signed [ACC_BIT-1:0]  qacc_q;
  logic                       sat_q;
  logic                       ovf_q;

  logic                       first;
  logic                       last;
  logic [LEN_BIT-1:0]         num_eff;
  logic [LEN_BIT-1:0]         cnt_inc;
  logic signed [63:0]         wide;
  logic signed [63:0]         acc_sat;
  logic                       sat_hit;
  qw_t                        qv;
  logic [ODATA_BIT-1:0]       qout;
  logic                       push;
  logic                       full;
  logic                       empty;
  logic                       drop;
  logic [ODATA_BIT-1:0]       fifo_dout;

  // Next accumulator value, partial count and FSM state.
  always_comb begin
    first   = (state_q == IDLE) || clear;
    num_eff = first ? ((cfg_acc_num == '0) ? LEN_BIT'(1) : cfg_acc_num)
                    : num_q;
    cnt_inc = first ? LEN_BIT'(1) : cnt_q + 1'b1;
    last    = idata_valid && (cnt_inc == num_eff);
    wide    = first ? 64'(idata) : 64'(acc_q) + 64'(idata);
    acc_sat = sat_n(wide, ACC_BIT);
    sat_hit = idata_valid && (acc_sat != wide);
    acc_d   = ACC_BIT'(acc_sat);
    cnt_d   = cnt_q;
    state_d = state_q;
    if (idata_valid) begin
      cnt_d   = last ? '0 : cnt_inc;
      state_d = last ? IDLE : ACC;
    end else if (clear) begin
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  // Bias, round-half-up, arithmetic shift, ReLU and output clamp.
  always_comb begin
    qv = qw_t'(qacc_q) + qw_t'(bias_q);
    if (shift_q != '0) qv = qv + (qw_t'(1) <<< (shift_q - 1'b1));
    qv = qv >>> shift_q;
    if (relu_q && qv < 0) qv = '0;
    qout = ODATA_BIT'(sat_n(64'(qv), ODATA_BIT));
  end

  assign push = qv_q && !clear;

  // Accumulator FSM, config latch, quant stage and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      shift_q <= '0;
      bias_q  <= '0;
      relu_q  <= 1'b0;
      acc_q   <= '0;
      qv_q    <= 1'b0;
      qacc_q  <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qv_q    <= last;
      if (idata_valid) acc_q <= acc_d;
      if (idata_valid && first) begin
        num_q   <= num_eff;
        shift_q <= cfg_shift;
        bias_q  <= cfg_bias;
        relu_q  <= cfg_relu;
      end
      if (last)    qacc_q <= acc_d;
      if (sat_hit) sat_q  <= 1'b1;
      if (drop)    ovf_q  <= 1'b1;
    end
  end

  acc_out_fifo #(
    .WIDTH (ODATA_BIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (qout),
    .pop_i   (odata_ready),
    .data_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty),
    .drop_o  (drop)
  );

  assign odata       = fifo_dout;
  assign odata_valid = !empty;
  assign busy        = (state_q == ACC) || qv_q;
  assign acc_sat_err = sat_q;
  assign ovf_err     = ovf_q;

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_core_acc_quant.sv
// Bench for core_acc_quant: directed cases plus random traffic
// against a queue-based behavioural model.
module tb_core_acc_quant;

  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         cfg_acc_num;
  logic [4:0]         cfg_shift;
  logic signed [31:0] cfg_bias;
  logic               cfg_relu;
  logic               clear;
  logic signed [21:0] idata;
  logic               idata_valid;
  logic signed [7:0]  odata;
  logic               odata_valid;
  logic               odata_ready;
  logic               busy;
  logic               acc_sat_err;
  logic               ovf_err;

  always #5 clk = ~clk;

  core_acc_quant dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_acc_num (cfg_acc_num),
    .cfg_shift   (cfg_shift),
    .cfg_bias    (cfg_bias),
    .cfg_relu    (cfg_relu),
    .clear       (clear),
    .idata       (idata),
    .idata_valid (idata_valid),
    .odata       (odata),
    .odata_valid (odata_valid),
    .odata_ready (odata_ready),
    .busy        (busy),
    .acc_sat_err (acc_sat_err),
    .ovf_err     (ovf_err)
  );

  int n_chk = 0;
  int n_err = 0;

  longint mq[$];
  bit     st_v;
  longint st_val;
  longint acc;
  int     cnt;
  int     lnum;
  int     lshift;
  longint lbias;
  bit     lrelu;
  bit     sat_e;
  bit     ovf_e;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint quant(input longint s);
    longint v;
    v = s + lbias;
    if (lshift > 0) v = v + (longint'(1) <<< (lshift - 1));
    v = v >>> lshift;
    if (lrelu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic model_edge();
    int sz;
    bit pop_b;
    if (rst) begin
      mq.delete();
      st_v = 0; cnt = 0; acc = 0;
      sat_e = 0; ovf_e = 0;
      return;
    end
    sz = mq.size();
    pop_b = (sz > 0) && odata_ready;
    if (pop_b) void'(mq.pop_front());
    if (st_v && !clear) begin
      if (sz < DEPTH || pop_b) mq.push_back(st_val);
      else ovf_e = 1;
    end
    st_v = 0;
    if (idata_valid) begin
      if (cnt == 0 || clear) begin
        lnum   = (cfg_acc_num == 0) ? 1 : int'(cfg_acc_num);
        lshift = int'(cfg_shift);
        lbias  = longint'(cfg_bias);
        lrelu  = cfg_relu;
        acc    = longint'(idata);
        cnt    = 1;
      end else begin
        acc = acc + longint'(idata);
        if (acc > 64'sd2147483647) begin acc = 64'sd2147483647; sat_e = 1; end
        if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; sat_e = 1; end
        cnt++;
      end
      if (cnt == lnum) begin
        st_v   = 1;
        st_val = quant(acc);
        cnt    = 0;
      end
    end else if (clear) begin
      cnt = 0;
    end
  endtask

  task automatic compare_all();
    chk("valid", odata_valid, mq.size() > 0);
    chk("odata", odata, (mq.size() > 0) ? mq[0] : 0);
    chk("busy", busy, (cnt != 0) || st_v);
    chk("sat", acc_sat_err, sat_e);
    chk("ovf", ovf_err, ovf_e);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic send(input bit v, input longint d);
    idata_valid = v;
    idata = 22'(d);
    step();
    idata_valid = 1'b0;
  endtask

  task automatic set_cfg(input int n, input int sh,
                         input int b, input bit r);
    cfg_acc_num = 8'(n);
    cfg_shift   = 5'(sh);
    cfg_bias    = 32'(b);
    cfg_relu    = r;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; idata_valid = 1'b0; idata = '0;
    odata_ready = 1'b1;
    set_cfg(1, 0, 0, 0);
    step();
    step();
    chk("rst_valid", odata_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // 260 + 2 >>> 2 = 65, visible for exactly one cycle
    set_cfg(4, 2, 0, 0);
    send(1, 100); send(1, 200); send(1, -50); send(1, 10);
    send(0, 0);
    chk("s1_valid", odata_valid, 1);
    chk("s1_val", odata, 65);
    send(0, 0);
    chk("s1_once", odata_valid, 0);

    // output saturation and ReLU
    set_cfg(2, 0, 0, 0);
    send(1, 1000); send(1, 1000); send(0, 0);
    chk("sat_hi", odata, 127);
    send(1, -1000); send(1, -1000); send(0, 0);
    chk("sat_lo", odata, -128);
    set_cfg(2, 0, 0, 1);
    send(1, -1000); send(1, -1000); send(0, 0);
    chk("relu_v", odata_valid, 1);
    chk("relu", odata, 0);
    send(0, 0);

    // rounding with num == 1
    set_cfg(1, 2, 0, 0);
    send(1, -6); send(0, 0);
    chk("rnd_m6", odata, -1);
    send(1, 6); send(0, 0);
    chk("rnd_6", odata, 2);
    set_cfg(1, 2, -10, 0);
    send(1, 2); send(0, 0);
    chk("rnd_bias", odata, -2);
    send(0, 0);

    // FIFO fill and overflow drop
    set_cfg(1, 0, 0, 0);
    odata_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(1, i);
    send(0, 0); send(0, 0);
    chk("ovf_set", ovf_err, 1);
    odata_ready = 1'b1;
    chk("fifo_0", odata, 1);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("fifo_n", odata, i);
    end
    step();
    chk("fifo_empty", odata_valid, 0);

    // clear with same-cycle first partial
    set_cfg(3, 0, 0, 0);
    send(1, 7); send(1, 7);
    clear = 1'b1;
    send(1, 5);
    clear = 1'b0;
    send(1, 5); send(1, 5); send(0, 0);
    chk("clr_val", odata, 15);
    send(0, 0);
    chk("clr_once", odata_valid, 0);

    // reset mid-accumulation
    set_cfg(4, 0, 0, 0);
    send(1, 1); send(1, 1);
    rst = 1'b1;
    step();
    chk("mrst_valid", odata_valid, 0);
    chk("mrst_odata", odata, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ovf", ovf_err, 0);
    chk("mrst_sat", acc_sat_err, 0);
    rst = 1'b0;
    send(0, 0);
    chk("mrst_busy2", busy, 0);
    for (int i = 0; i < 4; i++) send(1, 1);
    send(0, 0);
    chk("mrst_val", odata, 4);
    send(0, 0);

    // random traffic; config changes freely mid-accumulation
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      clear = ($urandom_range(0, 19) == 0);
      odata_ready = ($urandom_range(0, 2) != 0);
      set_cfg(int'($urandom_range(0, 5)), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 2000)) - 1000, 1'($urandom));
      idata_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) idata = 22'($urandom);
      else idata = 22'(int'($urandom_range(0, 4000)) - 2000);
      step();
    end
    rst = 1'b0; clear = 1'b0; idata_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
